// File: rtl/memory_types_pkg.sv
// Shared memory-side types: the request/response packet and the arbiter's requester IDs.
package memory_types_pkg;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic        we;
   } mem_pkt_t;

   typedef enum logic {IMEM = 1'b0, DMEM = 1'b1} mem_req_id_t;

   localparam int MEM_ARB_MAX_OUTSTANDING = 4;

endpackage

// File: rtl/arb_tag_fifo.sv
// In-order FIFO of requester tags for accepted-but-unanswered memory requests.
module arb_tag_fifo #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 1,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] tags [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = tags[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) tags[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction and data sides,
// routing in-order responses back to the requester recorded in the tag FIFO.
module mem_arbiter
   import memory_types_pkg::*;
#(
   parameter  int MAX_OUTSTANDING = MEM_ARB_MAX_OUTSTANDING,
   localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             imem_req_vld,
   output logic             imem_req_rdy,
   input  mem_pkt_t         imem_req,
   output logic             imem_rsp_vld,
   input  logic             imem_rsp_rdy,
   output mem_pkt_t         imem_rsp,
   input  logic             dmem_req_vld,
   output logic             dmem_req_rdy,
   input  mem_pkt_t         dmem_req,
   output logic             dmem_rsp_vld,
   input  logic             dmem_rsp_rdy,
   output mem_pkt_t         dmem_rsp,
   output logic             mem_req_vld,
   input  logic             mem_req_rdy,
   output mem_pkt_t         mem_req,
   input  logic             mem_rsp_vld,
   output logic             mem_rsp_rdy,
   input  mem_pkt_t         mem_rsp,
   output logic [CNT_W-1:0] outstanding,
   output logic             spurious_rsp_err
);

   mem_req_id_t last_grant;
   mem_req_id_t lock_id;
   mem_req_id_t grant;
   mem_req_id_t head_id;
   logic        lock;
   logic        full;
   logic        empty;
   logic        push;
   logic        pop;
   logic        grant_vld;
   logic        req_ok;
   logic [0:0]  head_raw;

   // A stalled downstream request keeps its grant so mem_req cannot change under it.
   always_comb begin
      grant = (last_grant == IMEM) ? DMEM : IMEM;
      if (lock)                              grant = lock_id;
      else if (imem_req_vld && !dmem_req_vld) grant = IMEM;
      else if (dmem_req_vld && !imem_req_vld) grant = DMEM;
   end

   assign grant_vld    = (grant == IMEM) ? imem_req_vld : dmem_req_vld;
   assign mem_req_vld  = rst_n && grant_vld && !full;
   assign mem_req      = (grant == IMEM) ? imem_req : dmem_req;
   assign req_ok       = rst_n && mem_req_rdy && !full;
   assign imem_req_rdy = req_ok && (grant == IMEM);
   assign dmem_req_rdy = req_ok && (grant == DMEM);
   assign push         = mem_req_vld && mem_req_rdy;

   assign head_id      = mem_req_id_t'(head_raw);
   assign imem_rsp_vld = mem_rsp_vld && !empty && (head_id == IMEM);
   assign dmem_rsp_vld = mem_rsp_vld && !empty && (head_id == DMEM);
   assign mem_rsp_rdy  = !empty && ((head_id == IMEM) ? imem_rsp_rdy : dmem_rsp_rdy);
   assign pop          = mem_rsp_vld && mem_rsp_rdy;
   assign imem_rsp     = mem_rsp;
   assign dmem_rsp     = mem_rsp;

   arb_tag_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (1)
   ) u_tag_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (grant),
      .pop       (pop),
      .head      (head_raw),
      .full      (full),
      .empty     (empty),
      .count     (outstanding)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant       <= DMEM;
         lock             <= 1'b0;
         lock_id          <= IMEM;
         spurious_rsp_err <= 1'b0;
      end else begin
         if (push) begin
            last_grant <= grant;
            lock       <= 1'b0;
         end else if (mem_req_vld) begin
            lock    <= 1'b1;
            lock_id <= grant;
         end
         if (mem_rsp_vld && empty) spurious_rsp_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter with an in-bench queue model plus directed scenarios.
module tb_mem_arbiter;
   import memory_types_pkg::*;

   localparam int MAXO = 4;

   logic       clk;
   logic       rst_n;
   logic       imem_req_vld, imem_req_rdy, imem_rsp_vld, imem_rsp_rdy;
   logic       dmem_req_vld, dmem_req_rdy, dmem_rsp_vld, dmem_rsp_rdy;
   logic       mem_req_vld, mem_req_rdy, mem_rsp_vld, mem_rsp_rdy;
   mem_pkt_t   imem_req, imem_rsp, dmem_req, dmem_rsp, mem_req, mem_rsp;
   logic [2:0] outstanding;
   logic       spurious_rsp_err;

   mem_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_vld(imem_req_vld), .imem_req_rdy(imem_req_rdy), .imem_req(imem_req),
      .imem_rsp_vld(imem_rsp_vld), .imem_rsp_rdy(imem_rsp_rdy), .imem_rsp(imem_rsp),
      .dmem_req_vld(dmem_req_vld), .dmem_req_rdy(dmem_req_rdy), .dmem_req(dmem_req),
      .dmem_rsp_vld(dmem_rsp_vld), .dmem_rsp_rdy(dmem_rsp_rdy), .dmem_rsp(dmem_rsp),
      .mem_req_vld(mem_req_vld), .mem_req_rdy(mem_req_rdy), .mem_req(mem_req),
      .mem_rsp_vld(mem_rsp_vld), .mem_rsp_rdy(mem_rsp_rdy), .mem_rsp(mem_rsp),
      .outstanding(outstanding), .spurious_rsp_err(spurious_rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errs = 0;
   int nchk = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      nchk++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: one in-order queue of (requester, addr) for every accepted request.
   typedef struct packed {
      logic        id;
      logic [31:0] addr;
   } ent_t;

   ent_t     mq[$];
   bit       last_m, lock_m, lock_side_m, err_m;
   int       n_m;
   bit       full_m, g_m, exp_mvld, hd_m, exp_rrdy;
   mem_pkt_t gp_m;

   always @(negedge clk) begin
      if (!rst_n) begin
         mq.delete();
         last_m = 1'b1;
         lock_m = 1'b0;
         lock_side_m = 1'b0;
         err_m = 1'b0;
      end else begin
         n_m = mq.size();
         full_m = (n_m == MAXO);
         if (lock_m) g_m = lock_side_m;
         else if (imem_req_vld && dmem_req_vld) g_m = !last_m;
         else g_m = dmem_req_vld;
         gp_m = g_m ? dmem_req : imem_req;
         exp_mvld = (g_m ? dmem_req_vld : imem_req_vld) && !full_m;

         chk("mdl_outstanding", outstanding, n_m);
         chk("mdl_err", spurious_rsp_err, err_m);
         chk("mdl_mem_req_vld", mem_req_vld, exp_mvld);
         if (exp_mvld) chk("mdl_mem_req", mem_req, gp_m);
         if (imem_req_vld || dmem_req_vld) begin
            chk("mdl_imem_req_rdy", imem_req_rdy, !g_m && mem_req_rdy && !full_m);
            chk("mdl_dmem_req_rdy", dmem_req_rdy, g_m && mem_req_rdy && !full_m);
         end
         hd_m = (n_m > 0) ? mq[0].id : 1'b0;
         chk("mdl_imem_rsp_vld", imem_rsp_vld, mem_rsp_vld && n_m > 0 && !hd_m);
         chk("mdl_dmem_rsp_vld", dmem_rsp_vld, mem_rsp_vld && n_m > 0 && hd_m);
         exp_rrdy = (n_m > 0) && (hd_m ? dmem_rsp_rdy : imem_rsp_rdy);
         chk("mdl_mem_rsp_rdy", mem_rsp_rdy, exp_rrdy);
         if (mem_rsp_vld) begin
            chk("mdl_imem_rsp", imem_rsp, mem_rsp);
            chk("mdl_dmem_rsp", dmem_rsp, mem_rsp);
         end

         if (mem_rsp_vld && n_m == 0) err_m = 1'b1;
         if (mem_rsp_vld && exp_rrdy) void'(mq.pop_front());
         if (exp_mvld && mem_req_rdy) begin
            mq.push_back('{id: g_m, addr: gp_m.addr});
            last_m = g_m;
            lock_m = 1'b0;
         end else if (exp_mvld) begin
            lock_m = 1'b1;
            lock_side_m = g_m;
         end
      end
   end

   function automatic mem_pkt_t rnd_pkt();
      mem_pkt_t p;
      p.addr = $urandom;
      p.data = $urandom;
      p.we   = 1'($urandom % 2);
      return p;
   endfunction

   function automatic mem_pkt_t mk_pkt(input logic [31:0] a);
      mem_pkt_t p;
      p.addr = a;
      p.data = ~a;
      p.we   = 1'b0;
      return p;
   endfunction

   task automatic step(input bit new_ok);
      bit ia, da, ra;
      @(negedge clk);
      ia = imem_req_vld && imem_req_rdy;
      da = dmem_req_vld && dmem_req_rdy;
      ra = mem_rsp_vld && mem_rsp_rdy;
      @(posedge clk);
      #1;
      if (!imem_req_vld || ia) begin
         imem_req_vld = new_ok && ($urandom % 3 != 0);
         imem_req = rnd_pkt();
      end
      if (!dmem_req_vld || da) begin
         dmem_req_vld = new_ok && ($urandom % 3 != 0);
         dmem_req = rnd_pkt();
      end
      mem_req_rdy = ($urandom % 4 != 0);
      if (!mem_rsp_vld || ra) begin
         mem_rsp_vld = (mq.size() > 0) && ($urandom % 2 != 0);
         if (mem_rsp_vld) mem_rsp = mk_pkt(mq[0].addr);
      end
      imem_rsp_rdy = ($urandom % 4 != 0);
      dmem_rsp_rdy = ($urandom % 4 != 0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      imem_req_vld = 0; dmem_req_vld = 0; mem_req_rdy = 0;
      mem_rsp_vld = 0; imem_rsp_rdy = 0; dmem_rsp_rdy = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      imem_req_vld = 1; dmem_req_vld = 0; mem_req_rdy = 1;
      mem_rsp_vld = 0; imem_rsp_rdy = 0; dmem_rsp_rdy = 0;
      imem_req = mk_pkt(32'h10); dmem_req = mk_pkt(32'h20); mem_rsp = mk_pkt(0);
      #12;
      chk("rst_imem_req_rdy", imem_req_rdy, 0);
      chk("rst_mem_req_vld", mem_req_vld, 0);
      chk("rst_outstanding", outstanding, 0);
      chk("rst_err", spurious_rsp_err, 0);
      do_reset();

      // Downstream stall: locked IMEM packet must hold, DMEM wins afterwards.
      imem_req_vld = 1; imem_req = mk_pkt(32'h100);
      dmem_req_vld = 1; dmem_req = mk_pkt(32'h200);
      mem_req_rdy = 0;
      repeat (3) begin
         @(negedge clk);
         chk("stall_vld", mem_req_vld, 1);
         chk("stall_addr", mem_req.addr, 32'h100);
         @(posedge clk);
         #1;
      end
      mem_req_rdy = 1;
      @(negedge clk);
      chk("stall_release_imem", imem_req_rdy, 1);
      @(posedge clk);
      #1;
      imem_req = mk_pkt(32'h104);
      @(negedge clk);
      chk("stall_next_dmem", dmem_req_rdy, 1);
      chk("stall_next_addr", mem_req.addr, 32'h200);
      do_reset();

      // Contention: grants alternate starting with IMEM, then the FIFO fills.
      imem_req_vld = 1; imem_req = mk_pkt(32'h1000);
      dmem_req_vld = 1; dmem_req = mk_pkt(32'h2000);
      mem_req_rdy = 1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("alt_imem_rdy", imem_req_rdy, (k % 2) == 0);
         chk("alt_dmem_rdy", dmem_req_rdy, (k % 2) == 1);
         @(posedge clk);
         #1;
         if (k % 2 == 0) imem_req = mk_pkt(imem_req.addr + 4);
         else            dmem_req = mk_pkt(dmem_req.addr + 4);
      end
      @(negedge clk);
      chk("full_outstanding", outstanding, 4);
      chk("full_imem_rdy", imem_req_rdy, 0);
      chk("full_dmem_rdy", dmem_req_rdy, 0);
      chk("full_mem_req_vld", mem_req_vld, 0);

      // Full plus simultaneous response: the pop wins, the push waits a cycle.
      @(posedge clk);
      #1;
      mem_rsp_vld = 1; mem_rsp = mk_pkt(mq[0].addr); imem_rsp_rdy = 1;
      @(negedge clk);
      chk("sim_mem_rsp_rdy", mem_rsp_rdy, 1);
      chk("sim_imem_req_blocked", imem_req_rdy, 0);
      @(posedge clk);
      #1;
      chk("sim_outstanding_3", outstanding, 3);
      mem_rsp_vld = 0;
      @(negedge clk);
      chk("sim_push_next", imem_req_rdy, 1);
      @(posedge clk);
      #1;
      chk("sim_outstanding_4", outstanding, 4);
      imem_req_vld = 0; dmem_req_vld = 0;

      for (int c = 0; c < 3000; c++) step(1);

      begin
         int c;
         for (c = 0; c < 400; c++) begin
            if (mq.size() == 0 && !imem_req_vld && !dmem_req_vld) break;
            step(0);
         end
         if (c == 400) chk("drain_timeout", 1, 0);
      end
      mem_rsp_vld = 0;
      @(negedge clk);
      chk("drain_outstanding", outstanding, 0);

      // Spurious response with an empty FIFO.
      @(posedge clk);
      #1;
      mem_rsp_vld = 1; mem_rsp = mk_pkt(32'hdead);
      @(negedge clk);
      chk("spur_rsp_rdy", mem_rsp_rdy, 0);
      @(posedge clk);
      #1;
      chk("spur_err", spurious_rsp_err, 1);
      mem_rsp_vld = 0;

      // Two IMEM requests outstanding, then async reset while a response stalls.
      imem_req_vld = 1; imem_req = mk_pkt(32'h3000); mem_req_rdy = 1;
      @(posedge clk);
      #1;
      imem_req = mk_pkt(32'h3004);
      @(posedge clk);
      #1;
      chk("ar_outstanding_2", outstanding, 2);
      imem_req_vld = 0;
      mem_rsp_vld = 1; mem_rsp = mk_pkt(32'h3000); imem_rsp_rdy = 0;
      @(negedge clk);
      chk("bp_imem_rsp_vld", imem_rsp_vld, 1);
      chk("bp_mem_rsp_rdy", mem_rsp_rdy, 0);
      chk("bp_dmem_rsp_vld", dmem_rsp_vld, 0);
      imem_req_vld = 1;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("ar_outstanding", outstanding, 0);
      chk("ar_err", spurious_rsp_err, 0);
      chk("ar_mem_req_vld", mem_req_vld, 0);
      chk("ar_imem_req_rdy", imem_req_rdy, 0);
      chk("ar_imem_rsp_vld", imem_rsp_vld, 0);
      chk("ar_mem_rsp_rdy", mem_rsp_rdy, 0);

      $display("Result: errors=%0d of %0d checks", errs, nchk);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one unified memory port between the core's instruction-side and data-side request/response interfaces. Both sides use mem_pkt_t valid/ready channels. The block sits between the core and a single-ported memory or bus bridge. It performs round-robin arbitration on requests, tracks requester IDs of outstanding transactions in order, and routes in-order responses back to the originating side.

Parameters:
MAX_OUTSTANDING, 4, max accepted-but-unanswered requests; power of two, >= 2
CNT_W, $clog2(MAX_OUTSTANDING)+1, width of outstanding counter (derived, not overridden)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
imem_req_vld  in  1  instruction-side request valid
imem_req_rdy  out  1  instruction-side request accepted
imem_req  in  mem_pkt_t  instruction-side request packet
imem_rsp_vld  out  1  instruction-side response valid
imem_rsp_rdy  in  1  instruction side can take response
imem_rsp  out  mem_pkt_t  instruction-side response packet
dmem_req_vld  in  1  data-side request valid
dmem_req_rdy  out  1  data-side request accepted
dmem_req  in  mem_pkt_t  data-side request packet
dmem_rsp_vld  out  1  data-side response valid
dmem_rsp_rdy  in  1  data side can take response
dmem_rsp  out  mem_pkt_t  data-side response packet
mem_req_vld  out  1  downstream request valid
mem_req_rdy  in  1  downstream accepts request
mem_req  out  mem_pkt_t  downstream request packet
mem_rsp_vld  in  1  downstream response valid
mem_rsp_rdy  out  1  arbiter accepts response
mem_rsp  in  mem_pkt_t  downstream response packet
outstanding  out  CNT_W  current number of outstanding requests
spurious_rsp_err  out  1  sticky: response arrived with no outstanding request

Behaviour:
- Reset (rst_n low, async) values:
  - all *_vld and *_rdy outputs 0.
  - outstanding 0; spurious_rsp_err 0.
  - tag FIFO empty.
  - last_grant = DMEM, so IMEM has first priority after reset.
  - lock flag 0.
- Handshake: a transfer occurs when vld && rdy in the same cycle. Once asserted, vld and the packet hold stable until the transfer.
- Request arbitration (combinational, zero latency):
  - Candidates are the sides with req_vld=1.
  - If both are valid, grant goes to the side that is not last_grant.
  - If lock=1, grant is held at the locked side regardless of the other request.
  - mem_req_vld = (granted side's req_vld) && !full.
  - mem_req = granted side's packet, unmodified.
  - granted side's req_rdy = mem_req_rdy && !full. The non-granted side's req_rdy = 0.
- Lock: set when mem_req_vld && !mem_req_rdy; cleared on the downstream transfer. This guarantees mem_req stability while stalled.
- On a downstream request transfer:
  - push the granted ID into the tag FIFO.
  - update last_grant to the granted side.
  - clear lock.
- full: outstanding == MAX_OUTSTANDING. A push is blocked when full, even if a pop occurs in the same cycle. There is no rsp-to-req combinational path.
- Response routing (combinational):
  - head = tag FIFO head ID.
  - imem_rsp_vld = mem_rsp_vld && !empty && head==IMEM; dmem_rsp_vld likewise for DMEM.
  - mem_rsp_rdy = !empty && (head side's rsp_rdy).
  - imem_rsp and dmem_rsp are both driven with mem_rsp; only the vld signals are steered.
  - Pop the FIFO on mem_rsp_vld && mem_rsp_rdy.
- outstanding counter: +1 on push, -1 on pop, unchanged on simultaneous push and pop. Range is 0..MAX_OUTSTANDING.
- FIFO pointers: log2(MAX_OUTSTANDING) bits, wrap modulo depth.
- Spurious response: mem_rsp_vld while empty gives mem_rsp_rdy=0, and spurious_rsp_err is set on the next edge. It stays set until reset.
- Responses are required to return in request order; no reordering is supported.
- Reset mid-transaction drops all tags. Downstream is reset by the same rst_n.

Decomposition:
- memory_types_pkg gains:
  - typedef enum logic {IMEM=1'b0, DMEM=1'b1} mem_req_id_t
  - localparam MEM_ARB_MAX_OUTSTANDING=4
- mem_pkt_t is reused unchanged.
- Sub-module arb_tag_fifo:
  - parameters DEPTH and WIDTH.
  - ports clk, rst_n, push, push_data, pop, head, full, empty, count.
  - The outstanding output and the full/empty flags come from it.

Test Plan:
- IMEM-only stream: imem_req_vld=1 for 4 cycles, mem_req_rdy=1 -> 4 downstream transfers with addr matching; outstanding reaches 4; imem_req_rdy=0 on the 5th; 4 responses return to imem_rsp_vld only; outstanding back to 0.
- Contention: both sides valid continuously, mem_req_rdy=1, responses immediate -> grants alternate IMEM, DMEM, IMEM, DMEM starting with IMEM after reset.
- Downstream stall: both sides valid, mem_req_rdy=0 for 3 cycles, then 1 -> mem_req stays the locked IMEM packet for all 3 cycles; DMEM gets the next grant.
- Response backpressure: outstanding IMEM then DMEM; mem_rsp_vld=1, imem_rsp_rdy=0 for 2 cycles -> mem_rsp_rdy=0, dmem_rsp_vld=0; after imem_rsp_rdy=1, the IMEM pop happens, then DMEM receives the next response.
- Full plus simultaneous: 4 outstanding, new request and response in the same cycle -> pop occurs, push blocked, outstanding=3; the push is accepted next cycle.
- Spurious and reset: mem_rsp_vld=1 with empty FIFO -> mem_rsp_rdy=0, spurious_rsp_err=1 next cycle. Async rst_n low mid-transaction with 2 outstanding -> outstanding=0, err=0, all vld=0 immediately.
